// File: rtl/command_sequencer.sv
// Command sequencer: queues command words in a small FIFO and feeds them one
// at a time to a compute core.  Each instruction is written (ISSUE), awaited
// (WAIT) until the core reports done or the watchdog expires, then followed
// by an all-zero write (CLEAR) that returns the engines to reset.  A one-cycle
// GAP then lets the core's done level fall before the next dispatch.
//
// Core write handshake: command_we0 is a single-cycle strobe.  The core must
// accept command_out on every cycle in which command_we0 is high; there is no
// back-pressure path from the core.
module command_sequencer #(
    parameter int CMD_W   = 35,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 65535
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [CMD_W-1:0]       cmd_in,
    input  logic                   cmd_push,
    output logic                   cmd_full,
    output logic [$clog2(DEPTH):0] cmd_count,
    input  logic                   run,
    output logic [CMD_W-1:0]       command_out,
    output logic                   command_we0,
    input  logic                   done_ins_computation,
    output logic                   busy,
    output logic                   seq_done,
    output logic                   timeout_err,
    input  logic                   err_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int WW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        CLEAR = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state;
    state_t           next_state;

    logic [CMD_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    logic [WW-1:0]    watchdog;
    logic             done_ok;

    logic             push_ok;
    logic             pop;
    logic             dispatch_ok;
    logic             timeout_fire;

    logic [CMD_W-1:0] nxt_command_out;
    logic             nxt_command_we0;
    logic             nxt_seq_done;

    // A push while full is dropped even if ISSUE pops in the same cycle.
    assign push_ok      = cmd_push && !cmd_full;
    assign pop          = (state == ISSUE);
    assign dispatch_ok  = run && (cmd_count != '0) && !timeout_err;
    // Done has priority over the watchdog in the same cycle.
    assign timeout_fire = (state == WAIT) && !done_ins_computation
                          && (watchdog == WW'(TIMEOUT - 1));
    assign cmd_full     = (cmd_count == CW'(DEPTH));
    assign busy         = (state != IDLE);

    // FIFO storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= cmd_in;
    end

    // FIFO pointers and occupancy; a watchdog expiry discards everything queued.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            cmd_count <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push_ok);
            if (timeout_fire) begin
                rd_ptr    <= wr_ptr;
                cmd_count <= CW'(push_ok);
            end else begin
                rd_ptr    <= rd_ptr + AW'(pop);
                cmd_count <= cmd_count + CW'(push_ok) - CW'(pop);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // Next-state logic; done is only looked at while waiting.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (dispatch_ok) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (done_ins_computation || timeout_fire) next_state = CLEAR;
            CLEAR:   next_state = GAP;
            GAP:     next_state = dispatch_ok ? ISSUE : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so the registered outputs line up with it.
    always_comb begin
        nxt_command_out = command_out;
        nxt_command_we0 = 1'b0;
        nxt_seq_done    = (state == GAP) && (next_state == IDLE)
                          && (cmd_count == '0) && done_ok;
        case (next_state)
            ISSUE: begin
                nxt_command_out = mem[rd_ptr];
                nxt_command_we0 = 1'b1;
            end
            CLEAR: begin
                nxt_command_out = '0;
                nxt_command_we0 = 1'b1;
            end
            default: ;
        endcase
    end

    // Registered core-facing outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            command_out <= '0;
            command_we0 <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            command_out <= nxt_command_out;
            command_we0 <= nxt_command_we0;
            seq_done    <= nxt_seq_done;
        end
    end

    // Watchdog, sticky error flag and the done-vs-timeout outcome of the last instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            watchdog    <= '0;
            timeout_err <= 1'b0;
            done_ok     <= 1'b0;
        end else begin
            if (state == ISSUE)     watchdog <= '0;
            else if (state == WAIT) watchdog <= watchdog + 1'b1;

            if (timeout_fire)  timeout_err <= 1'b1;
            else if (err_clr)  timeout_err <= 1'b0;

            if (state == WAIT && next_state == CLEAR) done_ok <= done_ins_computation;
        end
    end

endmodule

// File: tb/tb_command_sequencer.sv
// Bench for command_sequencer: a responder plays the compute core, a scoreboard
// checks every core write against an expected queue, and directed, table and
// random phases exercise dispatch, FIFO limits, timeout, run gating and reset.
module tb_command_sequencer;

  localparam int CMD_W   = 35;
  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 100;

  logic             clk;
  logic             rst;
  logic [CMD_W-1:0] cmd_in;
  logic             cmd_push;
  logic             cmd_full;
  logic [3:0]       cmd_count;
  logic             run;
  logic [CMD_W-1:0] command_out;
  logic             command_we0;
  logic             done_ins;
  logic             busy;
  logic             seq_done;
  logic             timeout_err;
  logic             err_clr;

  command_sequencer #(.CMD_W(CMD_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .cmd_in               (cmd_in),
    .cmd_push             (cmd_push),
    .cmd_full             (cmd_full),
    .cmd_count            (cmd_count),
    .run                  (run),
    .command_out          (command_out),
    .command_we0          (command_we0),
    .done_ins_computation (done_ins),
    .busy                 (busy),
    .seq_done             (seq_done),
    .timeout_err          (timeout_err),
    .err_clr              (err_clr)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [CMD_W-1:0] exp_q[$];
  int wr_cyc_q[$];
  int n_total = 0;
  int n_pass  = 0;
  int n_writes = 0;
  int n_seq = 0;
  int done_lat = 0;
  int dn_cnt = 0;
  bit in_flight = 0;
  int last_issue_cyc = 0;
  int last_clear_lat = 0;
  int done_rise_cyc = 0;
  int seq_cyc = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, exp);
  endfunction

  // Core model and write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      in_flight = 0;
      done_ins  = 1'b0;
      dn_cnt    = 0;
    end else begin
      if (command_we0) begin
        n_writes++;
        wr_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got 0x%0h, required no write", command_out);
        end else begin
          check("write_data", command_out, exp_q.pop_front());
        end
        if (!in_flight) begin
          in_flight      = 1;
          last_issue_cyc = cyc;
          dn_cnt         = done_lat;
        end else begin
          in_flight      = 0;
          done_ins       = 1'b0;
          last_clear_lat = cyc - last_issue_cyc;
        end
      end else if (in_flight && done_lat != 0 && !done_ins) begin
        dn_cnt--;
        if (dn_cnt == 0) begin
          done_ins      = 1'b1;
          done_rise_cyc = cyc;
        end
      end
      if (seq_done) begin
        n_seq++;
        seq_cyc = cyc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [CMD_W-1:0] d);
    cmd_in   = d;
    cmd_push = 1'b1;
    @(negedge clk);
    cmd_push = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int max_cyc);
    bit ok = 0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s: still busy after %0d cycles, %0d writes pending, required idle",
               name, max_cyc, exp_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_writes(input string name, input int target);
    bit ok = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (n_writes >= target) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      n_total++;
      $display("FAIL %s: got %0d writes, required %0d", name, n_writes, target);
    end
  endtask

  function automatic logic [CMD_W-1:0] rand_cmd();
    logic [CMD_W-1:0] d;
    d[31:0]  = $urandom;
    d[34:32] = 3'($urandom_range(0, 7));
    if (d[4:0] == 5'd0) d[0] = 1'b1;
    return d;
  endfunction

  typedef struct {
    logic             push;
    logic [CMD_W-1:0] data;
    int               exp_count;
    logic             exp_full;
  } vec_t;

  // ---------------- test sequence ----------------
  initial begin
    vec_t vt[10];
    logic [CMD_W-1:0] model_q[$];
    logic [CMD_W-1:0] d;
    int w0, s0, n, lat;

    for (int i = 0; i < 10; i++) begin
      vt[i].push      = (i < 9);
      vt[i].data      = 35'h1_0000_0000 + 35'(i) * 35'h111 + 35'h1;
      vt[i].exp_count = (i < 8) ? i + 1 : 8;
      vt[i].exp_full  = (i >= 7);
    end

    rst = 1'b1; cmd_in = '0; cmd_push = 1'b0; run = 1'b0; err_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_out", command_out, 0);
    check("rst_we0", command_we0, 0);
    check("rst_busy", busy, 0);
    check("rst_count", cmd_count, 0);
    check("rst_full", cmd_full, 0);
    check("rst_seq_done", seq_done, 0);
    check("rst_timeout_err", timeout_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single command, done 20 cycles after the write.
    done_lat = 20; w0 = n_writes; s0 = n_seq;
    exp_q.push_back(35'h18); exp_q.push_back('0);
    push_cmd(35'h18);
    run = 1'b1;
    wait_idle("single_idle", 200);
    check("single_writes", n_writes - w0, 2);
    check("single_seq_done", n_seq - s0, 1);
    check("single_issue_to_clear", last_clear_lat, 21);
    check("single_seq_delay", seq_cyc - done_rise_cyc, 3);
    check("single_busy", busy, 0);

    // Back-to-back with run high while pushing (overlaps a push with a pop).
    done_lat = 5; w0 = n_writes; s0 = n_seq;
    wr_cyc_q.delete();
    exp_q.push_back(35'd22); exp_q.push_back('0);
    exp_q.push_back(35'd23); exp_q.push_back('0);
    exp_q.push_back(35'd18); exp_q.push_back('0);
    push_cmd(35'd22); push_cmd(35'd23); push_cmd(35'd18);
    wait_idle("b2b_idle", 200);
    check("b2b_writes", n_writes - w0, 6);
    check("b2b_seq_done", n_seq - s0, 1);
    if (wr_cyc_q.size() == 6) begin
      check("b2b_gap1", wr_cyc_q[2] - wr_cyc_q[1], 2);
      check("b2b_gap2", wr_cyc_q[4] - wr_cyc_q[3], 2);
    end else begin
      check("b2b_write_log", wr_cyc_q.size(), 6);
    end
    run = 1'b0;

    // Full FIFO table: 9 pushes with run low, then one idle cycle.
    w0 = n_writes; s0 = n_seq;
    for (int i = 0; i < 10; i++) begin
      cmd_in   = vt[i].data;
      cmd_push = vt[i].push;
      @(negedge clk);
      cmd_push = 1'b0;
      check($sformatf("fill_count_%0d", i), cmd_count, vt[i].exp_count);
      check($sformatf("fill_full_%0d", i), cmd_full, vt[i].exp_full);
      if (i < 8) begin
        exp_q.push_back(vt[i].data);
        exp_q.push_back('0);
      end
    end
    check("fill_no_dispatch", busy, 0);
    run = 1'b1;
    wait_idle("fill_idle", 800);
    check("fill_writes", n_writes - w0, 16);
    check("fill_seq_done", n_seq - s0, 1);
    check("fill_count_after", cmd_count, 0);
    run = 1'b0;

    // Done and watchdog in the same cycle: done wins.
    done_lat = TIMEOUT; w0 = n_writes; s0 = n_seq;
    exp_q.push_back(35'h2A1); exp_q.push_back('0);
    exp_q.push_back(35'h2A2); exp_q.push_back('0);
    push_cmd(35'h2A1); push_cmd(35'h2A2);
    run = 1'b1;
    wait_idle("tie_idle", 600);
    check("tie_writes", n_writes - w0, 4);
    check("tie_issue_to_clear", last_clear_lat, TIMEOUT + 1);
    check("tie_timeout_err", timeout_err, 0);
    check("tie_seq_done", n_seq - s0, 1);
    run = 1'b0;

    // Timeout with 3 queued, err_clr coinciding with the set.
    done_lat = 0; w0 = n_writes; s0 = n_seq;
    exp_q.push_back(35'h31); exp_q.push_back('0);
    push_cmd(35'h31); push_cmd(35'h32); push_cmd(35'h33);
    run = 1'b1;
    wait_writes("to_issue", w0 + 1);
    while (cyc < last_issue_cyc + TIMEOUT) @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_set_beats_clr", timeout_err, 1);
    check("to_flush_count", cmd_count, 0);
    wait_idle("to_idle", 50);
    check("to_issue_to_clear", last_clear_lat, TIMEOUT + 1);
    check("to_writes", n_writes - w0, 2);
    check("to_no_seq_done", n_seq - s0, 0);
    check("to_err_sticky", timeout_err, 1);
    push_cmd(35'h34);
    repeat (5) @(negedge clk);
    check("to_blocked_busy", busy, 0);
    check("to_blocked_count", cmd_count, 1);
    done_lat = 15; s0 = n_seq;
    exp_q.push_back(35'h34); exp_q.push_back('0);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_cleared", timeout_err, 0);
    wait_idle("to_resume_idle", 200);
    check("to_resume_seq_done", n_seq - s0, 1);
    run = 1'b0;

    // Run dropped during WAIT of the first of two.
    done_lat = 20; w0 = n_writes; s0 = n_seq;
    exp_q.push_back(35'h41); exp_q.push_back('0);
    push_cmd(35'h41); push_cmd(35'h42);
    run = 1'b1;
    wait_writes("gate_issue", w0 + 1);
    @(negedge clk);
    run = 1'b0;
    repeat (50) @(negedge clk);
    check("gate_busy", busy, 0);
    check("gate_count", cmd_count, 1);
    check("gate_writes", n_writes - w0, 2);
    check("gate_no_seq_done", n_seq - s0, 0);
    exp_q.push_back(35'h42); exp_q.push_back('0);
    run = 1'b1;
    wait_idle("gate_idle", 200);
    check("gate_seq_done", n_seq - s0, 1);
    run = 1'b0;

    // Asynchronous reset in the middle of WAIT.
    done_lat = 0; w0 = n_writes; s0 = n_seq;
    exp_q.push_back(35'h51);
    push_cmd(35'h51);
    run = 1'b1;
    wait_writes("arst_issue", w0 + 1);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("arst_cmd_out", command_out, 0);
    check("arst_we0", command_we0, 0);
    check("arst_busy", busy, 0);
    check("arst_count", cmd_count, 0);
    check("arst_timeout_err", timeout_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (TIMEOUT + 20) @(negedge clk);
    check("arst_no_clear", n_writes - w0, 1);
    check("arst_no_err", timeout_err, 0);
    done_lat = 10; s0 = n_seq;
    exp_q.push_back(35'h52); exp_q.push_back('0);
    push_cmd(35'h52);
    wait_idle("arst_resume_idle", 200);
    check("arst_resume_seq_done", n_seq - s0, 1);
    run = 1'b0;

    // Random rounds against a queue model of the FIFO.
    for (int r = 0; r < 6; r++) begin
      model_q.delete();
      n   = $urandom_range(1, 10);
      lat = $urandom_range(1, 40);
      done_lat = lat; w0 = n_writes; s0 = n_seq;
      for (int k = 0; k < n; k++) begin
        d = rand_cmd();
        push_cmd(d);
        if (model_q.size() < DEPTH) model_q.push_back(d);
      end
      check($sformatf("rnd%0d_count", r), cmd_count, model_q.size());
      check($sformatf("rnd%0d_full", r), cmd_full, model_q.size() == DEPTH);
      foreach (model_q[k]) begin
        exp_q.push_back(model_q[k]);
        exp_q.push_back('0);
      end
      run = 1'b1;
      wait_idle($sformatf("rnd%0d_idle", r), 500);
      run = 1'b0;
      check($sformatf("rnd%0d_writes", r), n_writes - w0, 2 * model_q.size());
      check($sformatf("rnd%0d_seq_done", r), n_seq - s0, 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
